// File: rtl/seg_scan_mux_pkg.sv
// Shared output-port constants and scan FSM encoding for the seven-segment scan driver.
package seg_scan_mux_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW0 = 3'd1,
        DEAD0 = 3'd2,
        SHOW1 = 3'd3,
        DEAD1 = 3'd4
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] AN_NONE   = 2'b00;
    localparam logic [1:0] AN_DIG0   = 2'b01;
    localparam logic [1:0] AN_DIG1   = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_phase_counter.sv
// Phase counter for the scan FSM: counts up from zero, flags done at limit-1, clears on restart.
module scan_phase_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W:0]   limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // limit is one bit wider than cnt so a limit equal to 2**CNT_W stays representable
    assign done = ({1'b0, cnt} == (limit - (CNT_W+1)'(1)));

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit seven-segment scan driver with blanking between digits and a per-frame tick.
// Define SEG_SCAN_ACTIVE_LOW_EN for inverted (common-anode) seg_out/an_out polarity.
//
// state | meaning
// IDLE  | display blank, waiting for en
// SHOW0 | digit 0 lit with hold0
// DEAD0 | blank gap after digit 0
// SHOW1 | digit 1 lit with hold1
// DEAD1 | blank gap after digit 1, then next frame
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] reg1_seg,
    input  logic [6:0] reg2_seg,
    output logic [6:0] seg_out,
    output logic [1:0] an_out,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(max_int(CLK_DIV, DEAD_CYCLES));
    localparam logic [CNT_W:0] SHOW_LIM = (CNT_W+1)'(CLK_DIV);
    localparam logic [CNT_W:0] DEAD_LIM = (CNT_W+1)'(DEAD_CYCLES);

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_RST = ~SEG_BLANK;
    localparam logic [1:0] AN_RST  = ~AN_NONE;
`else
    localparam logic [6:0] SEG_RST = SEG_BLANK;
    localparam logic [1:0] AN_RST  = AN_NONE;
`endif

    scan_state_t      state, state_nxt;
    logic [6:0]       hold0, hold1, hold0_nxt, hold1_nxt;
    logic [6:0]       seg_nxt, seg_drv;
    logic [1:0]       an_nxt, an_drv;
    logic             tick_nxt;
    logic             restart, done;
    logic [CNT_W:0]   limit;

    scan_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .limit   (limit),
        .done    (done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SHOW0;
            SHOW0:   if (!en) state_nxt = IDLE; else if (done) state_nxt = DEAD0;
            DEAD0:   if (!en) state_nxt = IDLE; else if (done) state_nxt = SHOW1;
            SHOW1:   if (!en) state_nxt = IDLE; else if (done) state_nxt = DEAD1;
            DEAD1:   if (!en) state_nxt = IDLE; else if (done) state_nxt = SHOW0;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        restart   = (state_nxt != state) || (state == IDLE);
        limit     = (state == SHOW0 || state == SHOW1) ? SHOW_LIM : DEAD_LIM;
        // snapshot only on phase entry so mid-phase input changes never reach the bus
        hold0_nxt = (state_nxt == SHOW0 && state != SHOW0) ? reg1_seg : hold0;
        hold1_nxt = (state_nxt == SHOW1 && state != SHOW1) ? reg2_seg : hold1;
        tick_nxt  = (state == DEAD1) && (state_nxt == SHOW0);
        seg_nxt   = SEG_BLANK;
        an_nxt    = AN_NONE;
        case (state_nxt)
            SHOW0: begin
                seg_nxt = hold0_nxt;
                an_nxt  = AN_DIG0;
            end
            SHOW1: begin
                seg_nxt = hold1_nxt;
                an_nxt  = AN_DIG1;
            end
            default: begin
                seg_nxt = SEG_BLANK;
                an_nxt  = AN_NONE;
            end
        endcase
    end

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    assign seg_drv = ~seg_nxt;
    assign an_drv  = ~an_nxt;
`else
    assign seg_drv = seg_nxt;
    assign an_drv  = an_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold0      <= SEG_BLANK;
            hold1      <= SEG_BLANK;
            seg_out    <= SEG_RST;
            an_out     <= AN_RST;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold0      <= hold0_nxt;
            hold1      <= hold1_nxt;
            seg_out    <= seg_drv;
            an_out     <= an_drv;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux with CLK_DIV=4, DEAD_CYCLES=2.
module tb_seg_scan_mux;

    localparam int CLK_DIV     = 4;
    localparam int DEAD_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [6:0] reg1_seg = 7'h00;
    logic [6:0] reg2_seg = 7'h00;
    logic [6:0] seg_out;
    logic [1:0] an_out;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg_scan_mux #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .reg1_seg   (reg1_seg),
        .reg2_seg   (reg2_seg),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic       en;
        logic [6:0] r1;
        logic [6:0] r2;
        logic [6:0] seg;
        logic [1:0] an;
        logic       tick;
    } vec_t;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       tick;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tick_at[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    function automatic logic [6:0] ps(input logic [6:0] s);
`ifdef SEG_SCAN_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    function automatic logic [1:0] pa(input logic [1:0] a);
`ifdef SEG_SCAN_ACTIVE_LOW_EN
        return ~a;
`else
        return a;
`endif
    endfunction

    function automatic void add(input int n, input logic e, input logic [6:0] r1,
                                input logic [6:0] r2, input logic [6:0] seg,
                                input logic [1:0] an, input logic tick);
        vec_t v;
        v.en = e; v.r1 = r1; v.r2 = r2; v.seg = seg; v.an = an; v.tick = tick;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // expected values are given active-high and mapped to the build's output polarity here
    task automatic check(input string name, input logic [6:0] seg, input logic [1:0] an,
                         input logic tick);
        checks++;
        if (seg_out !== ps(seg) || an_out !== pa(an) || frame_tick !== tick) begin
            errors++;
            $display("FAIL %s: got seg=%h an=%b tick=%b, need seg=%h an=%b tick=%b",
                     name, seg_out, an_out, frame_tick, ps(seg), pa(an), tick);
        end
    endtask

    task automatic cyc(input string name, input logic e, input logic [6:0] r1,
                       input logic [6:0] r2, input logic [6:0] eseg,
                       input logic [1:0] ean, input logic etick);
        exp_t x;
        en = e; reg1_seg = r1; reg2_seg = r2;
        x.seg = eseg; x.an = ean; x.tick = etick;
        sb.push_back(x);
        @(posedge clk);
        #1;
        cyc_no++;
        if (frame_tick === 1'b1) tick_at.push_back(cyc_no);
        x = sb.pop_front();
        check(name, x.seg, x.an, x.tick);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp;

        // normal scan, with reg1 changed 66->06 during the 2nd SHOW0 of frame 2
        add(4, 1'b1, 7'h66, 7'h7F, 7'h66, 2'b01, 1'b0);
        add(2, 1'b1, 7'h66, 7'h7F, 7'h00, 2'b00, 1'b0);
        add(4, 1'b1, 7'h66, 7'h7F, 7'h7F, 2'b10, 1'b0);
        add(2, 1'b1, 7'h66, 7'h7F, 7'h00, 2'b00, 1'b0);
        add(1, 1'b1, 7'h66, 7'h7F, 7'h66, 2'b01, 1'b1);
        add(1, 1'b1, 7'h66, 7'h7F, 7'h66, 2'b01, 1'b0);
        add(2, 1'b1, 7'h06, 7'h7F, 7'h66, 2'b01, 1'b0);
        add(2, 1'b1, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        add(4, 1'b1, 7'h06, 7'h7F, 7'h7F, 2'b10, 1'b0);
        add(2, 1'b1, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        add(1, 1'b1, 7'h06, 7'h7F, 7'h06, 2'b01, 1'b1);
        add(3, 1'b1, 7'h06, 7'h7F, 7'h06, 2'b01, 1'b0);

        // async reset with no clock edge
        #1 rst = 1'b0;
        #1 check("reset_async", 7'h00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", 7'h00, 2'b00, 1'b0);
        end
        rst = 1'b1;

        foreach (vecs[i])
            cyc($sformatf("scan_%0d", i), vecs[i].en, vecs[i].r1, vecs[i].r2,
                vecs[i].seg, vecs[i].an, vecs[i].tick);

        checks++;
        sp = (tick_at.size() == 2) ? (tick_at[1] - tick_at[0]) : -1;
        if (sp != 2 * (CLK_DIV + DEAD_CYCLES)) begin
            errors++;
            $display("FAIL tick_period: got %0d (ticks seen %0d), need %0d",
                     sp, tick_at.size(), 2 * (CLK_DIV + DEAD_CYCLES));
        end

        // disable during 3rd SHOW1 cycle, then re-enable
        cyc("dis_dead0_a", 1'b1, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        cyc("dis_dead0_b", 1'b1, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        cyc("dis_show1_a", 1'b1, 7'h06, 7'h7F, 7'h7F, 2'b10, 1'b0);
        cyc("dis_show1_b", 1'b1, 7'h06, 7'h7F, 7'h7F, 2'b10, 1'b0);
        cyc("dis_show1_c", 1'b1, 7'h06, 7'h7F, 7'h7F, 2'b10, 1'b0);
        cyc("dis_idle",    1'b0, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        cyc("dis_idle2",   1'b0, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("reen_show0_%0d", i), 1'b1, 7'h06, 7'h7F, 7'h06, 2'b01, 1'b0);

        // en=0 on the SHOW0 terminal count must go to IDLE, not DEAD0
        cyc("tc_dis",      1'b0, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);
        cyc("tc_reen",     1'b1, 7'h06, 7'h7F, 7'h06, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("tc_show0_%0d", i), 1'b1, 7'h06, 7'h7F, 7'h06, 2'b01, 1'b0);
        cyc("tc_dead0",    1'b1, 7'h06, 7'h7F, 7'h00, 2'b00, 1'b0);

        // async reset mid-DEAD0, release with en=1
        #3 rst = 1'b0;
        #1 check("rst_mid_dead0", 7'h00, 2'b00, 1'b0);
        @(posedge clk);
        #1 check("rst_low_edge", 7'h00, 2'b00, 1'b0);
        #2 rst = 1'b1;
        cyc("rst_release", 1'b1, 7'h66, 7'h7F, 7'h66, 2'b01, 1'b0);
        cyc("rst_show0",   1'b1, 7'h66, 7'h7F, 7'h66, 2'b01, 1'b0);

        // async reset while a digit is lit blanks at once
        #3 rst = 1'b0;
        #1 check("rst_mid_show0", 7'h00, 2'b00, 1'b0);
        #2 rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
